// File: rtl/rv32i_mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between instruction fetch and load/store.
// One transaction in flight at a time; a silent memory is cut off by a WAIT-state timeout.
module rv32i_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                m_req,
   output logic                m_we,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   input  logic                m_ready,
   input  logic                m_rvalid,
   input  logic [DATA_W-1:0]   m_rdata,
   output logic                bus_err
);

   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
   localparam logic OWN_FETCH = 1'b0;
   localparam logic OWN_DATA  = 1'b1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t              state_q, state_d;
   logic                last_owner_q, last_owner_d;
   logic                owner_q, owner_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                m_we_q, m_we_d;
   logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
   logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
   logic [STRB_W-1:0]   m_wstrb_q, m_wstrb_d;
   logic                if_rvalid_q, if_rvalid_d;
   logic                d_rvalid_q, d_rvalid_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                bus_err_q, bus_err_d;

   logic                grant_if, grant_d;
   logic                done, done_err;

   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      owner_d      = owner_q;
      cnt_d        = cnt_q;
      m_we_d       = m_we_q;
      m_addr_d     = m_addr_q;
      m_wdata_d    = m_wdata_q;
      m_wstrb_d    = m_wstrb_q;
      if_rvalid_d  = 1'b0;
      d_rvalid_d   = 1'b0;
      if_rdata_d   = '0;
      d_rdata_d    = '0;
      bus_err_d    = 1'b0;
      grant_if     = 1'b0;
      grant_d      = 1'b0;
      done         = 1'b0;
      done_err     = 1'b0;

      case (state_q)
         S_IDLE: begin
            // On a tie the requester that did not own the bus last time wins.
            if (if_req && d_req) begin
               grant_d  = (last_owner_q == OWN_FETCH);
               grant_if = (last_owner_q == OWN_DATA);
            end else begin
               grant_if = if_req;
               grant_d  = d_req;
            end
            if (grant_if) begin
               m_we_d       = 1'b0;
               m_addr_d     = if_addr;
               m_wdata_d    = '0;
               m_wstrb_d    = '1;
               owner_d      = OWN_FETCH;
               last_owner_d = OWN_FETCH;
               state_d      = S_ISSUE;
            end else if (grant_d) begin
               m_we_d       = d_we;
               m_addr_d     = d_addr;
               m_wdata_d    = d_wdata;
               m_wstrb_d    = d_wstrb;
               owner_d      = OWN_DATA;
               last_owner_d = OWN_DATA;
               state_d      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (m_ready) begin
               if (m_rvalid) begin
                  done = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = '0;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            // A response arriving on the last allowed cycle still beats the timeout.
            if (m_rvalid) begin
               done = 1'b1;
            end else if ((TIMEOUT != 0) && (cnt_q == TO_VAL)) begin
               done     = 1'b1;
               done_err = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (done) begin
         state_d   = S_IDLE;
         bus_err_d = done_err;
         if (owner_q == OWN_FETCH) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = done_err ? '0 : m_rdata;
         end else begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = (done_err || m_we_q) ? '0 : m_rdata;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         last_owner_q <= OWN_FETCH;
         owner_q      <= OWN_FETCH;
         cnt_q        <= '0;
         m_we_q       <= 1'b0;
         m_addr_q     <= '0;
         m_wdata_q    <= '0;
         m_wstrb_q    <= '0;
         if_rvalid_q  <= 1'b0;
         d_rvalid_q   <= 1'b0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
         bus_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         owner_q      <= owner_d;
         cnt_q        <= cnt_d;
         m_we_q       <= m_we_d;
         m_addr_q     <= m_addr_d;
         m_wdata_q    <= m_wdata_d;
         m_wstrb_q    <= m_wstrb_d;
         if_rvalid_q  <= if_rvalid_d;
         d_rvalid_q   <= d_rvalid_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
         bus_err_q    <= bus_err_d;
      end
   end

   // Grants are combinational, so they must be masked while reset is held.
   assign if_gnt    = grant_if & ~rst;
   assign d_gnt     = grant_d & ~rst;
   assign m_req     = (state_q == S_ISSUE);
   assign m_we      = m_we_q;
   assign m_addr    = m_addr_q;
   assign m_wdata   = m_wdata_q;
   assign m_wstrb   = m_wstrb_q;
   assign if_rvalid = if_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign d_rvalid  = d_rvalid_q;
   assign d_rdata   = d_rdata_q;
   assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Randomized bench for rv32i_mem_arbiter: requesters and memory are scripted from a
// transaction-level timing model (grant, accept, response cycles) that predicts every output.
module tb_rv32i_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req, if_gnt, if_rvalid;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          d_req, d_we, d_gnt, d_rvalid;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata, d_rdata;
   logic [SW-1:0] d_wstrb;
   logic          m_req, m_we, m_ready, m_rvalid, bus_err;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rdata;
   logic [SW-1:0] m_wstrb;

   rv32i_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
      .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Model of the transaction in flight: grant, accept and completion cycles.
   int          t_g = -100, t_a = -100, t_c = -100, t_resp = -100;
   bit          t_to, t_own, t_we, last_own;
   logic [31:0] t_addr, t_wdata, t_mdata, t_rdata;
   logic [3:0]  t_wstrb;

   // Requester intent and one-shot memory behaviour overrides.
   bit          if_pend, d_pend, d_we_v;
   logic [31:0] if_a, d_a, d_wd;
   logic [3:0]  d_ws;
   int          fr_rd = -1, fr_resp = -1;
   logic [31:0] fr_data;
   bit          fr_data_en, gen_en, stray_once;
   int          exp_rv_if = 0, exp_rv_d = 0, obs_rv_if = 0, obs_rv_d = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".m_req"},     64'(m_req),     64'd0);
      chk({tag, ".m_we"},      64'(m_we),      64'd0);
      chk({tag, ".m_addr"},    64'(m_addr),    64'd0);
      chk({tag, ".m_wdata"},   64'(m_wdata),   64'd0);
      chk({tag, ".m_wstrb"},   64'(m_wstrb),   64'd0);
      chk({tag, ".if_rvalid"}, 64'(if_rvalid), 64'd0);
      chk({tag, ".d_rvalid"},  64'(d_rvalid),  64'd0);
      chk({tag, ".if_rdata"},  64'(if_rdata),  64'd0);
      chk({tag, ".d_rdata"},   64'(d_rdata),   64'd0);
      chk({tag, ".bus_err"},   64'(bus_err),   64'd0);
      chk({tag, ".if_gnt"},    64'(if_gnt),    64'd0);
      chk({tag, ".d_gnt"},     64'(d_gnt),     64'd0);
   endtask

   task automatic step();
      bit exp_mreq, exp_if_rv, exp_d_rv, gi, gd;
      int rd, rs;
      @(negedge clk);
      cyc++;
      exp_mreq  = (cyc >= t_g + 1) && (cyc <= t_a);
      exp_if_rv = (cyc == t_c + 1) && !t_own;
      exp_d_rv  = (cyc == t_c + 1) && t_own;
      if (if_rvalid) obs_rv_if++;
      if (d_rvalid)  obs_rv_d++;
      chk("m_req", 64'(m_req), 64'(exp_mreq));
      if (exp_mreq) begin
         chk("m_we",    64'(m_we),    64'(t_we));
         chk("m_addr",  64'(m_addr),  64'(t_addr));
         chk("m_wdata", 64'(m_wdata), 64'(t_wdata));
         chk("m_wstrb", 64'(m_wstrb), 64'(t_wstrb));
      end
      chk("if_rvalid", 64'(if_rvalid), 64'(exp_if_rv));
      chk("d_rvalid",  64'(d_rvalid),  64'(exp_d_rv));
      chk("bus_err",   64'(bus_err),   64'((cyc == t_c + 1) && t_to));
      if (exp_if_rv) begin
         exp_rv_if++;
         chk("if_rdata", 64'(if_rdata), 64'(t_rdata));
      end
      if (exp_d_rv) begin
         exp_rv_d++;
         chk("d_rdata", 64'(d_rdata), 64'(t_rdata));
      end
      if (exp_if_rv || exp_d_rv)
         $display("txn %s addr=0x%08h we=%0d rdata=0x%08h timeout=%0d",
                  t_own ? "DATA " : "FETCH", t_addr, t_we, t_rdata, t_to);

      // Memory side: accept at t_a, answer at t_resp, stray pulses only where they must be ignored.
      m_rdata = $urandom();
      if (cyc >= t_g + 1 && cyc <= t_a) begin
         m_ready  = (cyc == t_a);
         m_rvalid = (cyc == t_a) ? (cyc == t_resp) : (gen_en && $urandom_range(0, 4) == 0);
      end else if (cyc > t_a && cyc <= t_c) begin
         m_ready  = 1'($urandom_range(0, 1));
         m_rvalid = (cyc == t_resp);
      end else begin
         m_ready    = gen_en ? 1'($urandom_range(0, 1)) : 1'b0;
         m_rvalid   = stray_once || (gen_en && $urandom_range(0, 4) == 0);
         stray_once = 1'b0;
      end
      if (cyc == t_resp) m_rdata = t_mdata;

      if (gen_en) begin
         if (!if_pend) begin
            if_a = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 99) < 35) if_pend = 1'b1;
         end else if ($urandom_range(0, 99) < 3) begin
            if_pend = 1'b0;
         end
         if (!d_pend) begin
            d_a    = $urandom();
            d_wd   = $urandom();
            d_ws   = 4'($urandom_range(1, 15));
            d_we_v = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 35) d_pend = 1'b1;
         end else if ($urandom_range(0, 99) < 3) begin
            d_pend = 1'b0;
         end
      end
      if_req  = if_pend;
      if_addr = if_a;
      d_req   = d_pend;
      d_we    = d_we_v;
      d_addr  = d_a;
      d_wdata = d_wd;
      d_wstrb = d_ws;
      #1;

      gi = 1'b0;
      gd = 1'b0;
      if (cyc > t_c) begin
         if (if_pend && d_pend) begin
            gd = !last_own;
            gi = last_own;
         end else begin
            gi = if_pend;
            gd = d_pend;
         end
      end
      chk("if_gnt", 64'(if_gnt), 64'(gi));
      chk("d_gnt",  64'(d_gnt),  64'(gd));

      if (gi || gd) begin
         t_own    = gd;
         last_own = gd;
         t_we     = gd ? d_we_v : 1'b0;
         t_addr   = gd ? d_a : if_a;
         t_wdata  = gd ? d_wd : 32'h0;
         t_wstrb  = gd ? d_ws : 4'hF;
         rd = (fr_rd >= 0) ? fr_rd : ($urandom_range(0, 1) ? 0 : int'($urandom_range(1, 4)));
         if (fr_resp >= 0) rs = fr_resp;
         else begin
            case ($urandom_range(0, 19))
               0, 1, 2, 3, 4: rs = 0;
               5, 6:          rs = TO + 1;
               7, 8:          rs = TO + 2 + int'($urandom_range(0, 3));
               default:       rs = int'($urandom_range(1, TO));
            endcase
         end
         t_g = cyc;
         t_a = cyc + 1 + rd;
         if (rs <= TO + 1) begin
            t_to   = 1'b0;
            t_c    = t_a + rs;
            t_resp = t_c;
         end else begin
            t_to   = 1'b1;
            t_c    = t_a + 1 + TO;
            t_resp = -100;
         end
         t_mdata = fr_data_en ? fr_data : $urandom();
         t_rdata = (t_to || t_we) ? 32'h0 : t_mdata;
         fr_rd = -1;
         fr_resp = -1;
         fr_data_en = 1'b0;
         if (gi) if_pend = 1'b0;
         else    d_pend  = 1'b0;
      end
   endtask

   task automatic drain();
      gen_en  = 1'b0;
      if_pend = 1'b0;
      d_pend  = 1'b0;
      for (int k = 0; k < 40 && cyc <= t_c + 1; k++) step();
      chk("drain_idle", 64'(cyc > t_c + 1), 64'd1);
   endtask

   initial begin
      rst = 1'b1;
      {if_req, d_req, d_we, m_ready, m_rvalid} = '0;
      if_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0; m_rdata = '0;
      if_a = '0; d_a = '0; d_wd = '0; d_ws = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      if_req = 1'b1;
      d_req  = 1'b1;
      #1;
      chk_all_zero("reset");
      if_req = 1'b0;
      d_req  = 1'b0;
      rst    = 1'b0;

      gen_en = 1'b1;
      repeat (1500) step();
      drain();

      // Single fetch: accept at cycle 1, respond at cycle 3, rvalid at 4.
      if_pend = 1'b1; if_a = 32'h100;
      fr_rd = 0; fr_resp = 2; fr_data = 32'h0050_0093; fr_data_en = 1'b1;
      repeat (6) step();

      // Store held off 5 cycles by backpressure, then a zero-wait accept+response.
      d_pend = 1'b1; d_we_v = 1'b1; d_a = 32'h2000; d_wd = 32'hCAFE_F00D; d_ws = 4'hF;
      fr_rd = 5; fr_resp = 0;
      repeat (10) step();

      // Load that times out, with a fetch queued behind it.
      d_pend = 1'b1; d_we_v = 1'b0; d_a = 32'h3000;
      fr_rd = 0; fr_resp = 99;
      step();
      if_pend = 1'b1; if_a = 32'h104;
      repeat (14) step();
      drain();

      // Reset in the middle of WAIT drops the transaction.
      d_pend = 1'b1; d_we_v = 1'b1; d_a = 32'h4000; d_wd = 32'h1234_5678; d_ws = 4'h3;
      fr_rd = 0; fr_resp = 99;
      repeat (4) step();
      @(negedge clk);
      rst = 1'b1;
      if_req = 1'b1;
      d_req  = 1'b1;
      #1;
      chk_all_zero("rst_wait");
      @(negedge clk);
      chk_all_zero("rst_hold");
      {if_req, d_req, m_ready, m_rvalid} = '0;
      rst = 1'b0;
      last_own = 1'b0;
      t_g = -100; t_a = -100; t_c = -100; t_resp = -100;
      if_pend = 1'b0; d_pend = 1'b0;
      stray_once = 1'b1;
      repeat (3) step();
      if_pend = 1'b1; if_a = 32'h200;
      d_pend = 1'b1; d_we_v = 1'b0; d_a = 32'h5000;
      step();
      drain();

      chk("if_rvalid_count", 64'(obs_rv_if), 64'(exp_rv_if));
      chk("d_rvalid_count",  64'(obs_rv_d),  64'(exp_rv_d));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
